core_run_ctrl: RTL and testbench

CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

---
 rtl/core_run_ctrl_if.sv | 23 ++
 rtl/core_run_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_core_run_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_run_ctrl_if.sv
// core_run_ctrl_if: host command and program-load channel of the run controller.
// Handshake: a command transfers on a rising edge where host_cmd_valid and
// host_cmd_ready are both high. host_cmd and host_len must be stable while
// host_cmd_valid is high. host_wvalid has no ready. The controller takes every
// word offered while it is loading and ignores host_wvalid at all other times.
interface core_run_ctrl_if;
  logic        host_cmd_valid;
  logic        host_cmd_ready;
  logic [1:0]  host_cmd;
  logic [9:0]  host_len;
  logic        host_wvalid;
  logic [31:0] host_wdata;

  modport master (
    output host_cmd_valid, host_cmd, host_len, host_wvalid, host_wdata,
    input  host_cmd_ready
  );

  modport slave (
    input  host_cmd_valid, host_cmd, host_len, host_wvalid, host_wdata,
    output host_cmd_ready
  );
endinterface

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: host-driven program loader and run/step/halt controller for a
// small core. It writes program words into instruction memory and gates the
// core's commit enable. It stops on ecall/ebreak, on a host HALT, or after a
// single step.
// Optional feature: define CORE_RUN_CTRL_CYCLE_CNT_EN to build the
// committed-cycle counter. Without it, cycle_count is tied to 0.
module core_run_ctrl #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  core_run_ctrl_if.slave    host,
  output logic              im_we,
  output logic [31:0]       im_waddr,
  output logic [31:0]       im_wdata,
  input  logic [31:0]       core_instr,
  output logic              core_rst_n,
  output logic              core_en,
  output logic [1:0]        halt_cause,
  output logic [2:0]        state,
  output logic [31:0]       cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_STEP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  localparam logic [1:0] CMD_LOAD = 2'b00;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_HALT = 2'b11;

  localparam logic [1:0] HC_NONE = 2'b00;
  localparam logic [1:0] HC_HOST = 2'b01;
  localparam logic [1:0] HC_TRAP = 2'b10;
  localparam logic [1:0] HC_STEP = 2'b11;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  // host_len is 10 bits wide, so the load length can never exceed 1023.
  localparam int          LEN_CAP   = (MAX_WORDS > 1023) ? 1023 : MAX_WORDS;
  localparam logic [9:0]  LEN_CAP_W = LEN_CAP[9:0];

  state_t      r_state;
  logic [9:0]  r_len;
  logic [9:0]  r_wcnt;
  logic [1:0]  r_halt_cause;
  logic        r_ready;
  logic        r_core_rst_n;
  logic        r_run_en;

  logic        w_accept;
  logic        w_trap;
  logic [9:0]  w_len_clamp;

  assign w_accept    = host.host_cmd_valid & r_ready;
  assign w_trap      = (core_instr == INSTR_ECALL) || (core_instr == INSTR_EBREAK);
  assign w_len_clamp = (host.host_len > LEN_CAP_W) ? LEN_CAP_W : host.host_len;

  // Registered per-state outputs {cmd_ready, core_rst_n, run_en} for the state being entered.
  function automatic logic [2:0] state_outs(input state_t s);
    case (s)
      S_IDLE:  state_outs = 3'b100;
      S_LOAD:  state_outs = 3'b000;
      S_RUN:   state_outs = 3'b111;
      S_STEP:  state_outs = 3'b011;
      S_HALT:  state_outs = 3'b110;
      default: state_outs = 3'b100;
    endcase
  endfunction

  // Main control FSM: command decode, load word counting, halt cause tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_wcnt       <= '0;
      r_halt_cause <= HC_NONE;
      {r_ready, r_core_rst_n, r_run_en} <= state_outs(S_IDLE);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (host.host_cmd)
              CMD_LOAD: begin
                r_state <= S_LOAD;
                r_len   <= w_len_clamp;
                r_wcnt  <= '0;
                {r_ready, r_core_rst_n, r_run_en} <= state_outs(S_LOAD);
              end
              CMD_RUN: begin
                r_state <= S_RUN;
                {r_ready, r_core_rst_n, r_run_en} <= state_outs(S_RUN);
              end
              CMD_STEP: begin
                r_state <= S_STEP;
                {r_ready, r_core_rst_n, r_run_en} <= state_outs(S_STEP);
              end
              default: ;
            endcase
          end
        end
        S_LOAD: begin
          if (r_len == '0) begin
            r_state <= S_IDLE;
            {r_ready, r_core_rst_n, r_run_en} <= state_outs(S_IDLE);
          end else if (host.host_wvalid) begin
            r_wcnt <= r_wcnt + 10'd1;
            if (r_wcnt == r_len - 10'd1) begin
              r_state <= S_IDLE;
              {r_ready, r_core_rst_n, r_run_en} <= state_outs(S_IDLE);
            end
          end
        end
        S_RUN: begin
          // A trap wins over a host HALT in the same cycle.
          if (w_trap) begin
            r_state      <= S_HALT;
            r_halt_cause <= HC_TRAP;
            {r_ready, r_core_rst_n, r_run_en} <= state_outs(S_HALT);
          end else if (w_accept && host.host_cmd == CMD_HALT) begin
            r_state      <= S_HALT;
            r_halt_cause <= HC_HOST;
            {r_ready, r_core_rst_n, r_run_en} <= state_outs(S_HALT);
          end
        end
        S_STEP: begin
          r_state      <= S_HALT;
          r_halt_cause <= w_trap ? HC_TRAP : HC_STEP;
          {r_ready, r_core_rst_n, r_run_en} <= state_outs(S_HALT);
        end
        S_HALT: begin
          if (w_accept) begin
            r_halt_cause <= HC_NONE;
            case (host.host_cmd)
              CMD_LOAD: begin
                r_state <= S_LOAD;
                r_len   <= w_len_clamp;
                r_wcnt  <= '0;
                {r_ready, r_core_rst_n, r_run_en} <= state_outs(S_LOAD);
              end
              CMD_RUN: begin
                r_state <= S_RUN;
                {r_ready, r_core_rst_n, r_run_en} <= state_outs(S_RUN);
              end
              CMD_STEP: begin
                r_state <= S_STEP;
                {r_ready, r_core_rst_n, r_run_en} <= state_outs(S_STEP);
              end
              default: begin
                r_state <= S_IDLE;
                {r_ready, r_core_rst_n, r_run_en} <= state_outs(S_IDLE);
              end
            endcase
          end
        end
        default: begin
          r_state <= S_IDLE;
          {r_ready, r_core_rst_n, r_run_en} <= state_outs(S_IDLE);
        end
      endcase
    end
  end

  assign host.host_cmd_ready = r_ready;
  assign core_rst_n          = r_core_rst_n;
  // The trap instruction must not commit, so it masks the enable combinationally.
  assign core_en             = r_run_en & ~w_trap;
  assign halt_cause          = r_halt_cause;
  assign state               = r_state;
  assign im_we               = (r_state == S_LOAD) && (r_len != '0) && host.host_wvalid;
  assign im_waddr            = BOOT_ADDR + {20'd0, r_wcnt, 2'b00};
  assign im_wdata            = host.host_wdata;

`ifdef CORE_RUN_CTRL_CYCLE_CNT_EN
  logic [31:0] r_cycle_count;
  logic        w_load_start;

  // LOAD can only be entered from IDLE or HALT.
  assign w_load_start = w_accept && (host.host_cmd == CMD_LOAD) &&
                        ((r_state == S_IDLE) || (r_state == S_HALT));

  // Committed-cycle counter: clears on LOAD entry and saturates at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle_count <= '0;
    end else if (w_load_start) begin
      r_cycle_count <= '0;
    end else if (core_en && (r_cycle_count != 32'hFFFF_FFFF)) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  assign cycle_count = r_cycle_count;
`else
  assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: directed table-driven bench for core_run_ctrl, plus
// hand-written sequences for long loads, traps, steps and asynchronous reset.
// The expected cycle_count values follow CORE_RUN_CTRL_CYCLE_CNT_EN.
module tb_core_run_ctrl;

  localparam logic [1:0]  C_LOAD = 2'b00;
  localparam logic [1:0]  C_RUN  = 2'b01;
  localparam logic [1:0]  C_STEP = 2'b10;
  localparam logic [1:0]  C_HALT = 2'b11;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] WA = 32'hA0A0_0001;
  localparam logic [31:0] WB = 32'hB0B0_0002;
  localparam logic [31:0] WC = 32'hC0C0_0003;
  localparam logic [31:0] WD = 32'hD0D0_0004;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] core_instr;
  logic        im_we;
  logic [31:0] im_waddr;
  logic [31:0] im_wdata;
  logic        core_rst_n;
  logic        core_en;
  logic [1:0]  halt_cause;
  logic [2:0]  state;
  logic [31:0] cycle_count;

  always #5 clk = ~clk;

  core_run_ctrl_if u_if ();

  core_run_ctrl #(.BOOT_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut (
    .clk         (clk),
    .reset       (reset),
    .host        (u_if.slave),
    .im_we       (im_we),
    .im_waddr    (im_waddr),
    .im_wdata    (im_wdata),
    .core_instr  (core_instr),
    .core_rst_n  (core_rst_n),
    .core_en     (core_en),
    .halt_cause  (halt_cause),
    .state       (state),
    .cycle_count (cycle_count)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ecc(input logic [31:0] v);
`ifdef CORE_RUN_CTRL_CYCLE_CNT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic cv, input logic [1:0] cmd, input logic [9:0] len,
                       input logic wv, input logic [31:0] wd, input logic [31:0] instr);
    u_if.host_cmd_valid = cv;
    u_if.host_cmd       = cmd;
    u_if.host_len       = len;
    u_if.host_wvalid    = wv;
    u_if.host_wdata     = wd;
    core_instr          = instr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        cv;
    logic [1:0]  cmd;
    logic [9:0]  len;
    logic        wv;
    logic [31:0] wd;
    logic [31:0] instr;
    logic [2:0]  e_state;
    logic        e_ready;
    logic        e_we;
    logic [31:0] e_waddr;
    logic        e_en;
    logic        e_rstn;
    logic [1:0]  e_hc;
    logic [31:0] e_cc;
  } vec_t;

  localparam int NV = 25;
  vec_t tv [NV];

  initial begin
    int n_wr;
    logic [31:0] last_addr;
    logic done;

    // cv cmd len wv wd instr | state ready we waddr en rstn hc cc
    tv[0]  = '{0, C_LOAD, 10'd0, 0, 32'd0, NOP,    3'd0, 1, 0, 32'd0, 0, 0, 2'd0, 32'd0};
    tv[1]  = '{1, C_LOAD, 10'd3, 0, 32'd0, NOP,    3'd0, 1, 0, 32'd0, 0, 0, 2'd0, 32'd0};
    tv[2]  = '{0, C_LOAD, 10'd0, 1, WA,    NOP,    3'd1, 0, 1, 32'd0, 0, 0, 2'd0, 32'd0};
    tv[3]  = '{0, C_LOAD, 10'd0, 0, 32'd0, NOP,    3'd1, 0, 0, 32'd4, 0, 0, 2'd0, 32'd0};
    tv[4]  = '{0, C_LOAD, 10'd0, 1, WB,    NOP,    3'd1, 0, 1, 32'd4, 0, 0, 2'd0, 32'd0};
    tv[5]  = '{0, C_LOAD, 10'd0, 1, WC,    NOP,    3'd1, 0, 1, 32'd8, 0, 0, 2'd0, 32'd0};
    tv[6]  = '{0, C_LOAD, 10'd0, 1, WD,    NOP,    3'd0, 1, 0, 32'd0, 0, 0, 2'd0, 32'd0};
    tv[7]  = '{1, C_RUN,  10'd0, 0, 32'd0, NOP,    3'd0, 1, 0, 32'd0, 0, 0, 2'd0, 32'd0};
    tv[8]  = '{0, C_RUN,  10'd0, 0, 32'd0, NOP,    3'd2, 1, 0, 32'd0, 1, 1, 2'd0, ecc(0)};
    tv[9]  = '{1, C_LOAD, 10'd5, 0, 32'd0, NOP,    3'd2, 1, 0, 32'd0, 1, 1, 2'd0, ecc(1)};
    tv[10] = '{1, C_HALT, 10'd0, 0, 32'd0, NOP,    3'd2, 1, 0, 32'd0, 1, 1, 2'd0, ecc(2)};
    tv[11] = '{0, C_HALT, 10'd0, 0, 32'd0, NOP,    3'd4, 1, 0, 32'd0, 0, 1, 2'd1, ecc(3)};
    tv[12] = '{1, C_STEP, 10'd0, 0, 32'd0, NOP,    3'd4, 1, 0, 32'd0, 0, 1, 2'd1, ecc(3)};
    tv[13] = '{0, C_STEP, 10'd0, 0, 32'd0, NOP,    3'd3, 0, 0, 32'd0, 1, 1, 2'd0, ecc(3)};
    tv[14] = '{0, C_STEP, 10'd0, 0, 32'd0, NOP,    3'd4, 1, 0, 32'd0, 0, 1, 2'd3, ecc(4)};
    tv[15] = '{1, C_RUN,  10'd0, 0, 32'd0, NOP,    3'd4, 1, 0, 32'd0, 0, 1, 2'd3, ecc(4)};
    tv[16] = '{1, C_HALT, 10'd0, 0, 32'd0, EBREAK, 3'd2, 1, 0, 32'd0, 0, 1, 2'd0, ecc(4)};
    tv[17] = '{0, C_HALT, 10'd0, 0, 32'd0, NOP,    3'd4, 1, 0, 32'd0, 0, 1, 2'd2, ecc(4)};
    tv[18] = '{1, C_STEP, 10'd0, 0, 32'd0, NOP,    3'd4, 1, 0, 32'd0, 0, 1, 2'd2, ecc(4)};
    tv[19] = '{0, C_STEP, 10'd0, 0, 32'd0, ECALL,  3'd3, 0, 0, 32'd0, 0, 1, 2'd0, ecc(4)};
    tv[20] = '{1, C_HALT, 10'd0, 0, 32'd0, NOP,    3'd4, 1, 0, 32'd0, 0, 1, 2'd2, ecc(4)};
    tv[21] = '{1, C_HALT, 10'd0, 0, 32'd0, NOP,    3'd0, 1, 0, 32'd0, 0, 0, 2'd0, ecc(4)};
    tv[22] = '{1, C_LOAD, 10'd0, 0, 32'd0, NOP,    3'd0, 1, 0, 32'd0, 0, 0, 2'd0, ecc(4)};
    tv[23] = '{0, C_LOAD, 10'd0, 1, WA,    NOP,    3'd1, 0, 0, 32'd0, 0, 0, 2'd0, 32'd0};
    tv[24] = '{0, C_LOAD, 10'd0, 0, 32'd0, NOP,    3'd0, 1, 0, 32'd0, 0, 0, 2'd0, 32'd0};

    // Reset state, with a stray wvalid that must not write.
    reset = 1'b0;
    drive(0, C_LOAD, 10'd0, 1, WA, NOP);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_ready", {31'd0, u_if.host_cmd_ready}, 32'd1);
    chk("rst_we", {31'd0, im_we}, 32'd0);
    chk("rst_en", {31'd0, core_en}, 32'd0);
    chk("rst_rstn", {31'd0, core_rst_n}, 32'd0);
    chk("rst_hc", {30'd0, halt_cause}, 32'd0);
    chk("rst_cc", cycle_count, 32'd0);
    tick();
    reset = 1'b1;

    // Table: inputs apply for one cycle, outputs sampled at the falling edge.
    for (int i = 0; i < NV; i++) begin
      drive(tv[i].cv, tv[i].cmd, tv[i].len, tv[i].wv, tv[i].wd, tv[i].instr);
      @(negedge clk);
      chk($sformatf("v%0d_state", i), {29'd0, state}, {29'd0, tv[i].e_state});
      chk($sformatf("v%0d_ready", i), {31'd0, u_if.host_cmd_ready}, {31'd0, tv[i].e_ready});
      chk($sformatf("v%0d_we", i), {31'd0, im_we}, {31'd0, tv[i].e_we});
      if (tv[i].e_we) begin
        chk($sformatf("v%0d_waddr", i), im_waddr, tv[i].e_waddr);
        chk($sformatf("v%0d_wdata", i), im_wdata, tv[i].wd);
      end
      chk($sformatf("v%0d_en", i), {31'd0, core_en}, {31'd0, tv[i].e_en});
      chk($sformatf("v%0d_rstn", i), {31'd0, core_rst_n}, {31'd0, tv[i].e_rstn});
      chk($sformatf("v%0d_hc", i), {30'd0, halt_cause}, {30'd0, tv[i].e_hc});
      chk($sformatf("v%0d_cc", i), cycle_count, tv[i].e_cc);
      tick();
    end

    // Oversized LOAD is clamped to 256 words, the last at 0x3FC.
    drive(1, C_LOAD, 10'd1000, 0, 32'd0, NOP);
    tick();
    n_wr = 0;
    last_addr = 32'd0;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      drive(0, C_LOAD, 10'd0, 1, 32'(i), NOP);
      @(negedge clk);
      if (im_we) begin
        n_wr++;
        last_addr = im_waddr;
      end
      if (state == 3'd0) done = 1'b1;
      tick();
    end
    drive(0, C_LOAD, 10'd0, 0, 32'd0, NOP);
    chk("big_load_done", {31'd0, done}, 32'd1);
    chk("big_load_nwr", n_wr, 32'd256);
    chk("big_load_last", last_addr, 32'h0000_03FC);

    // RUN with ebreak on cycle 5: no commit, HALT with trap cause, count 5.
    drive(1, C_RUN, 10'd0, 0, 32'd0, NOP);
    tick();
    for (int c = 0; c < 6; c++) begin
      drive(0, C_RUN, 10'd0, 0, 32'd0, (c == 5) ? EBREAK : NOP);
      @(negedge clk);
      chk($sformatf("trap_run_en_c%0d", c), {31'd0, core_en}, (c == 5) ? 32'd0 : 32'd1);
      tick();
    end
    drive(0, C_RUN, 10'd0, 0, 32'd0, NOP);
    @(negedge clk);
    chk("trap_state", {29'd0, state}, 32'd4);
    chk("trap_hc", {30'd0, halt_cause}, 32'd2);
    chk("trap_cc", cycle_count, ecc(5));
    tick();

    // Three single steps from HALT.
    for (int k = 0; k < 3; k++) begin
      drive(1, C_STEP, 10'd0, 0, 32'd0, NOP);
      @(negedge clk);
      tick();
      drive(0, C_STEP, 10'd0, 0, 32'd0, NOP);
      @(negedge clk);
      chk($sformatf("step%0d_state", k), {29'd0, state}, 32'd3);
      chk($sformatf("step%0d_en", k), {31'd0, core_en}, 32'd1);
      tick();
      @(negedge clk);
      chk($sformatf("step%0d_halt", k), {29'd0, state}, 32'd4);
      chk($sformatf("step%0d_hc", k), {30'd0, halt_cause}, 32'd3);
      chk($sformatf("step%0d_cc", k), cycle_count, ecc(32'(6 + k)));
      tick();
    end

    // 100-cycle RUN; host HALT on the last cycle, which still commits.
    drive(1, C_RUN, 10'd0, 0, 32'd0, NOP);
    tick();
    for (int i = 0; i < 100; i++) begin
      drive((i == 99), C_HALT, 10'd0, 0, 32'd0, NOP);
      @(negedge clk);
      chk($sformatf("run100_cc%0d", i), cycle_count, ecc(32'(8 + i)));
      tick();
    end
    drive(0, C_HALT, 10'd0, 0, 32'd0, NOP);
    @(negedge clk);
    chk("run100_state", {29'd0, state}, 32'd4);
    chk("run100_hc", {30'd0, halt_cause}, 32'd1);
    chk("run100_cc", cycle_count, ecc(108));
    tick();

    // LOAD from HALT, then asynchronous reset in the middle of the load.
    drive(1, C_LOAD, 10'd10, 0, 32'd0, NOP);
    tick();
    drive(0, C_LOAD, 10'd0, 1, 32'h11, NOP);
    @(negedge clk);
    chk("rl_w0_addr", im_waddr, 32'd0);
    chk("rl_hc_clr", {30'd0, halt_cause}, 32'd0);
    tick();
    drive(0, C_LOAD, 10'd0, 1, 32'h22, NOP);
    @(negedge clk);
    chk("rl_w1_addr", im_waddr, 32'd4);
    tick();
    #1 reset = 1'b0;
    #1;
    chk("rl_state", {29'd0, state}, 32'd0);
    chk("rl_we", {31'd0, im_we}, 32'd0);
    chk("rl_rstn", {31'd0, core_rst_n}, 32'd0);
    chk("rl_ready", {31'd0, u_if.host_cmd_ready}, 32'd1);
    chk("rl_cc", cycle_count, 32'd0);
    #1 reset = 1'b1;
    // First command after reset release is taken on the first rising edge.
    drive(1, C_RUN, 10'd0, 0, 32'd0, NOP);
    @(negedge clk);
    chk("post_rst_state", {29'd0, state}, 32'd0);
    tick();
    drive(0, C_RUN, 10'd0, 0, 32'd0, NOP);
    @(negedge clk);
    chk("post_rst_run", {29'd0, state}, 32'd2);
    chk("post_rst_en", {31'd0, core_en}, 32'd1);
    // Asynchronous reset in the middle of RUN.
    #2 reset = 1'b0;
    #1;
    chk("rr_state", {29'd0, state}, 32'd0);
    chk("rr_en", {31'd0, core_en}, 32'd0);
    chk("rr_rstn", {31'd0, core_rst_n}, 32'd0);
    #1 reset = 1'b1;
    tick();

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
